bus_client_burst: RTL and testbench

BUS_CLIENT_BURST -- requirements
Module: bus_client_burst

---
 rtl/bus_client_burst.sv | 152 +++++++++++++++
 tb/tb_bus_client_burst.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_client_burst.sv
// Burst bus client: alternating write/readback bursts over a wrapping address window,
// LFSR-paced request starts, readback error counting. Define BUS_CLIENT_TIMEOUT_EN for beat timeouts.
module bus_client_burst #(
  parameter int        DATA_WIDTH           = 8,
  parameter int        ADDR_WIDTH           = 4,
  parameter int        ADDR_SPACE_BEGINNING = 0,
  parameter int        ADDR_SPACE_END       = 3,
  parameter logic [4:0] LFSR_SEED           = 5'b00101,
  parameter int        BURST_LEN            = 4,
  parameter int        TIMEOUT_CYCLES       = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  rq,
  input  logic                  ack,
  output logic                  wr_ni,
  output logic [DATA_WIDTH-1:0] dataW,
  input  logic [DATA_WIDTH-1:0] dataR,
  output logic                  done,
  output logic [7:0]            err_cnt,
  output logic                  timeout,
  output logic [1:0]            state_dbg
);

  // Handshake: rq is high for every BURST cycle; a beat transfers on a rising edge where
  // rq=1 and ack=1. Until then address, dataW and wr_ni hold; for reads, ack also
  // qualifies dataR on that same edge.

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2} state_t;

  localparam logic [ADDR_WIDTH-1:0] A_BEGIN   = ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
  localparam logic [ADDR_WIDTH-1:0] A_END     = ADDR_WIDTH'(ADDR_SPACE_END);
  localparam logic [7:0]            LAST_BEAT = 8'(BURST_LEN - 1);

  if (ADDR_SPACE_END < ADDR_SPACE_BEGINNING) begin : g_bad_range
    $error("ADDR_SPACE_END must be >= ADDR_SPACE_BEGINNING");
  end
  if (LFSR_SEED == 5'd0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end
  if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_len
    $error("BURST_LEN must be 1..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  state_t                 state;
  logic [4:0]             lfsr;
  logic [ADDR_WIDTH-1:0]  start_addr;
  logic [DATA_WIDTH-1:0]  base;
  logic [7:0]             beat_cnt;

  logic                   accept;
  logic                   last_beat;
  logic                   mismatch;
  logic                   tmo_hit;
  logic                   err_inc;
  logic [DATA_WIDTH-1:0]  exp_rd;
  logic [ADDR_WIDTH-1:0]  next_addr;

  assign state_dbg = state;
  assign accept    = rq & ack;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign exp_rd    = base + DATA_WIDTH'(beat_cnt);
  assign mismatch  = accept & wr_ni & (dataR != exp_rd);
  assign err_inc   = mismatch | tmo_hit;
  assign next_addr = (address == A_END) ? A_BEGIN : address + 1'b1;

`ifdef BUS_CLIENT_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled BURST cycle.
  assign tmo_hit = rq & ~ack & (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= tmo_hit;
      if (rq && !ack && !tmo_hit) wait_cnt <= wait_cnt + 8'd1;
      else                        wait_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      rq         <= 1'b0;
      wr_ni      <= 1'b0;
      done       <= 1'b0;
      address    <= A_BEGIN;
      dataW      <= '0;
      start_addr <= A_BEGIN;
      base       <= '0;
      beat_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      case (state)
        IDLE: begin
          lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
          if (lfsr[0]) begin
            state      <= BURST;
            rq         <= 1'b1;
            start_addr <= address;
            beat_cnt   <= '0;
            if (!wr_ni) base <= dataW;
          end
        end

        BURST: begin
          if (tmo_hit) begin
            // Abort and rewind so the same burst is retried from scratch.
            state    <= IDLE;
            rq       <= 1'b0;
            address  <= start_addr;
            beat_cnt <= '0;
            if (!wr_ni) dataW <= base;
          end else if (accept) begin
            if (!wr_ni) dataW <= dataW + 1'b1;
            if (last_beat) begin
              state    <= DONE;
              rq       <= 1'b0;
              done     <= 1'b1;
              beat_cnt <= '0;
              wr_ni    <= ~wr_ni;
              // Write bursts rewind for readback; read bursts move on.
              address  <= wr_ni ? next_addr : start_addr;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              address  <= next_addr;
            end
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_client_burst.sv
// Bench for bus_client_burst: directed vector table, hand-written corner sequences and a
// randomized run checked against a burst-level reference model.
module tb_bus_client_burst;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int L  = 4;
  localparam int A_LO = 0;
  localparam int A_HI = 3;
  localparam logic [4:0] SEED = 5'b00101;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ack, rq, wr_ni, done, timeout;
  logic [AW-1:0] address;
  logic [DW-1:0] data_w, data_r;
  logic [7:0]    err_cnt;
  logic [1:0]    state_dbg;

  logic          ack2, rq2, wr2, done2, tmo2;
  logic [AW-1:0] address2;
  logic [DW-1:0] dw2, data_r2;
  logic [7:0]    err2;
  logic [1:0]    st2;

  assign ack2    = 1'b1;
  assign data_r2 = '0;

  bus_client_burst dut (
    .clk(clk), .reset(rst), .address(address), .rq(rq), .ack(ack), .wr_ni(wr_ni),
    .dataW(data_w), .dataR(data_r), .done(done), .err_cnt(err_cnt), .timeout(timeout),
    .state_dbg(state_dbg)
  );

  bus_client_burst #(.ADDR_SPACE_BEGINNING(2), .ADDR_SPACE_END(4), .BURST_LEN(4)) dut2 (
    .clk(clk), .reset(rst), .address(address2), .rq(rq2), .ack(ack2), .wr_ni(wr2),
    .dataW(dw2), .dataR(data_r2), .done(done2), .err_cnt(err2), .timeout(tmo2),
    .state_dbg(st2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst    = 1'b1;
    ack    = 1'b1;
    data_r = '0;
    repeat (3) @(negedge clk);
    check("rst_rq", rq, 0);
    check("rst_wr_ni", wr_ni, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_dataW", data_w, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_address", address, A_LO);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [4:0]      m_lfsr;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data, m_base;
  logic            m_wr;
  int              m_err;
  logic [AW+DW:0]  exp_q[$];
  logic [DW-1:0]   rd_q[$];

  function automatic logic [4:0] lfsr_step(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  // Idle cycles before the next burst: LFSR values are consumed until one has bit0 set.
  function automatic int next_gap();
    int n = 0;
    logic b;
    do begin
      n++;
      b = m_lfsr[0];
      m_lfsr = lfsr_step(m_lfsr);
    end while (!b);
    return n;
  endfunction

  function automatic logic [AW-1:0] addr_at(input logic [AW-1:0] start, input int i);
    return AW'(A_LO + ((int'(start) - A_LO + i) % (A_HI - A_LO + 1)));
  endfunction

  function automatic void load_burst();
    if (!m_wr) m_base = m_data;
    for (int i = 0; i < L; i++) begin
      exp_q.push_back({m_wr, addr_at(m_addr, i), m_wr ? m_data : DW'(m_data + i)});
      if (m_wr) rd_q.push_back(DW'(m_base + i));
    end
  endfunction

  function automatic void finish_burst();
    if (!m_wr) begin
      m_data = DW'(m_data + L);
      m_wr   = 1'b1;
    end else begin
      m_addr = addr_at(m_addr, L);
      m_wr   = 1'b0;
    end
  endfunction

  // Starts at the negedge where reset was just released.
  task automatic run_random(input int n, input int bad_pct);
    logic [AW+DW:0] e;
    logic [DW-1:0]  er;
    logic           bad;
    int             ph, idle_left, zeros;
    m_addr = AW'(A_LO); m_data = '0; m_base = '0; m_wr = 1'b0; m_err = 0; m_lfsr = SEED;
    exp_q.delete(); rd_q.delete();
    ph = 0; idle_left = next_gap(); zeros = 0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      check("rnd_err_cnt", err_cnt, m_err);
      check("rnd_timeout", timeout, 0);
      ack    = 1'b1;
      data_r = DW'($urandom_range(0, 255));
      bad    = 1'b0;
      case (ph)
        0: begin
          check("rnd_rq_idle", rq, 0);
          check("rnd_done_idle", done, 0);
          idle_left--;
          if (idle_left == 0) begin
            load_burst();
            ph = 1;
          end
        end
        1: begin
          e = exp_q[0];
          check("rnd_rq_burst", rq, 1);
          check("rnd_wr_ni", wr_ni, e[AW+DW]);
          check("rnd_address", address, e[AW+DW-1:DW]);
          check("rnd_dataW", data_w, e[DW-1:0]);
          if (zeros >= 4) ack = 1'b1;
          else            ack = ($urandom_range(0, 3) != 0);
          zeros = ack ? 0 : zeros + 1;
          if (m_wr) begin
            er     = rd_q[0];
            bad    = ($urandom_range(1, 100) <= bad_pct);
            data_r = bad ? (er ^ DW'($urandom_range(1, 255))) : er;
          end
          if (ack) begin
            if (bad && m_err != 255) m_err++;
            void'(exp_q.pop_front());
            if (m_wr) void'(rd_q.pop_front());
            if (exp_q.size() == 0) begin
              finish_burst();
              ph = 2;
            end
          end
        end
        default: begin
          check("rnd_done_pulse", done, 1);
          check("rnd_rq_done", rq, 0);
          ph = 0;
          idle_left = next_gap();
        end
      endcase
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          ack;
    logic [DW-1:0] dr;
    logic          rq;
    logic [AW-1:0] addr;
    logic [DW-1:0] dw;
    logic          wr;
    logic          done;
    logic [7:0]    err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic a, input int dr, input logic r, input int ad,
                              input int dw, input logic w, input logic d, input int er);
    vec_t v;
    v.ack = a; v.dr = DW'(dr); v.rq = r; v.addr = AW'(ad); v.dw = DW'(dw);
    v.wr = w; v.done = d; v.err = 8'(er);
    tbl.push_back(v);
  endfunction

  logic [AW-1:0] got2_q[$];
  int            exp2[9] = '{2, 3, 4, 2, 2, 3, 4, 2, 3};
  int            cnt;

  initial begin
    rst = 1'b1; ack = 1'b1; data_r = '0;

    // Write 0..3, readback clean, write 4..7, readback with beat 2 corrupted.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 1, i, i, 0, 0, 0);
    add(1, 0, 0, 0, 4, 0, 1, 0);
    add(1, 0, 0, 0, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, i, 1, i, 4, 1, 0, 0);
    add(1, 0, 0, 0, 4, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 1, i, 4 + i, 0, 0, 0);
    add(1, 0, 0, 0, 8, 0, 1, 0);
    add(1, 0, 0, 0, 8, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, (i == 2) ? 8'hFF : 4 + i, 1, i, 8, 1, 0, (i == 3) ? 1 : 0);
    add(1, 0, 0, 0, 8, 0, 1, 1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) @(negedge clk);
      ack    = tbl[i].ack;
      data_r = tbl[i].dr;
      check("tbl_rq", rq, tbl[i].rq);
      check("tbl_address", address, tbl[i].addr);
      check("tbl_dataW", data_w, tbl[i].dw);
      if (tbl[i].rq) check("tbl_wr_ni", wr_ni, tbl[i].wr);
      check("tbl_done", done, tbl[i].done);
      check("tbl_err_cnt", err_cnt, tbl[i].err);
      check("tbl_timeout", timeout, 0);
      if (rq2 && ack2) got2_q.push_back(address2);
    end

    // Shifted address window: write 2,3,4,2 / read 2,3,4,2 / next write at 3.
    check("win_beats", (got2_q.size() >= 9) ? 1 : 0, 1);
    for (int i = 0; i < 9 && i < got2_q.size(); i++) check("win_address", got2_q[i], exp2[i]);

    // Asynchronous reset mid-cycle clears everything before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_rq", rq, 0);
    check("async_err_cnt", err_cnt, 0);
    check("async_dataW", data_w, 0);
    check("async_done", done, 0);

    // ack stalled for three cycles during beat 1.
    do_reset();
    @(negedge clk);
    check("stall_b0_addr", address, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack = (i == 3);
      check("stall_rq", rq, 1);
      check("stall_address", address, 1);
      check("stall_dataW", data_w, 1);
    end
    @(negedge clk);
    check("stall_next_address", address, 2);
    check("stall_next_dataW", data_w, 2);

    // Reset during beat 2 of the first write burst.
    do_reset();
    repeat (3) @(negedge clk);
    check("mid_b2_address", address, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rq", rq, 0);
    check("mid_address", address, 0);
    check("mid_dataW", data_w, 0);
    check("mid_err_cnt", err_cnt, 0);
    @(negedge clk);
    check("mid_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_restart_rq", rq, 1);
    check("mid_restart_address", address, 0);
    check("mid_restart_dataW", data_w, 0);
    check("mid_restart_wr_ni", wr_ni, 0);

`ifdef BUS_CLIENT_TIMEOUT_EN
    // ack held low from the start: 15 request cycles then a timeout pulse.
    do_reset();
    ack = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rq) cnt++;
      else if (cnt > 0) break;
    end
    check("tmo_cycles", cnt, 15);
    check("tmo_pulse", timeout, 1);
    check("tmo_rq", rq, 0);
    check("tmo_err_cnt", err_cnt, 1);
    check("tmo_done", done, 0);
    ack = 1'b1;
    @(negedge clk);
    check("tmo_pulse_end", timeout, 0);
    cnt = 0;
    while (!rq && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("tmo_retry_rq", rq, 1);
    check("tmo_retry_address", address, 0);
    check("tmo_retry_dataW", data_w, 0);
    check("tmo_retry_wr_ni", wr_ni, 0);

    // Timeout after one accepted beat rewinds address and data to the burst start.
    do_reset();
    @(negedge clk);
    ack = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rq) cnt++;
      else break;
    end
    check("tmo2_cycles", cnt, 15);
    check("tmo2_pulse", timeout, 1);
    check("tmo2_address", address, 0);
    check("tmo2_dataW", data_w, 0);
    ack = 1'b1;
`else
    // Without timeouts a stalled burst waits indefinitely.
    do_reset();
    ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("hold_rq", rq, 1);
        check("hold_address", address, 0);
      end
      check("hold_timeout", timeout, 0);
    end
    ack = 1'b1;
`endif

    // Randomized runs: light corruption, then heavy corruption to reach saturation.
    do_reset();
    run_random(600, 25);
    do_reset();
    run_random(2500, 100);
    check("err_saturated", err_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
